// File: rtl/iq_gain_ramp_ctrl.sv
// Multi-channel IQ gain stage: the gain ramps linearly toward a commanded target, with a
// post-multiply shift and saturation, a PA-mute ramp-down and a serial command/readback port.
module iq_gain_ramp_ctrl #(
    parameter int          DW        = 16,
    parameter int          GW        = 16,
    parameter int          CH_NUM    = 2,
    parameter int          MAX_SHIFT = 8,
    parameter int          RAMP_DIV  = 50,
    parameter logic [GW-1:0] GAIN_INIT = 16'h7FFF,
    parameter logic [15:0] STEP_INIT = 16'h0100
) (
    input  logic                     clk_50m,
    input  logic                     rst,
    input  logic                     rv_uart_vld,
    input  logic [63:0]              rv_uart_data,
    input  logic                     power_en,
    input  logic [CH_NUM-1:0]        din_stat,
    input  logic [CH_NUM*2*DW-1:0]   data_in,
    output logic [CH_NUM*2*DW-1:0]   data_out,
    output logic [CH_NUM-1:0]        dout_stat,
    output logic                     ramp_busy,
    output logic                     uart_send_en,
    output logic [63:0]              sd_uart_data
);

    localparam int LANES = 2 * CH_NUM;
    localparam int PW    = DW + GW;
    localparam int AW    = ((GW > 16) ? GW : 16) + 2;
    localparam int PSW   = $clog2(RAMP_DIV + 1);
    localparam logic signed [PW-1:0] SAT_MAX = PW'(2**(DW-1) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - 1;

    typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2} state_t;

    state_t           state_reg;
    logic [GW-1:0]    gain_cur_reg;
    logic [GW-1:0]    gain_tgt_reg;
    logic [3:0]       shift_reg;
    logic [15:0]      step_reg;
    logic [PSW-1:0]   presc_reg;

    logic [GW-1:0]        eff_tgt;
    logic [GW-1:0]        cmd_gain;
    logic signed [AW-1:0] cur_ext, tgt_ext, step_ext, sum_up, sum_dn;
    logic [GW-1:0]        up_next, dn_next;
    logic                 tick;

    // Gains are kept non-negative, so zero-extension into a wider signed space is exact.
    always_comb begin
        eff_tgt  = power_en ? gain_tgt_reg : '0;
        cmd_gain = rv_uart_data[GW-1] ? '0 : rv_uart_data[GW-1:0];
        cur_ext  = {{(AW-GW){1'b0}}, gain_cur_reg};
        tgt_ext  = {{(AW-GW){1'b0}}, eff_tgt};
        step_ext = {{(AW-16){1'b0}}, step_reg};
        sum_up   = cur_ext + step_ext;
        sum_dn   = cur_ext - step_ext;
        up_next  = (sum_up > tgt_ext) ? eff_tgt : sum_up[GW-1:0];
        dn_next  = (sum_dn < tgt_ext) ? eff_tgt : sum_dn[GW-1:0];
        tick     = (presc_reg == PSW'(RAMP_DIV - 1));
    end

    assign ramp_busy = (state_reg != IDLE);

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_reg    <= IDLE;
            gain_cur_reg <= GAIN_INIT;
            gain_tgt_reg <= GAIN_INIT;
            shift_reg    <= '0;
            step_reg     <= STEP_INIT;
            presc_reg    <= '0;
            uart_send_en <= 1'b0;
            sd_uart_data <= '0;
        end else begin
            uart_send_en <= 1'b0;
            if (rv_uart_vld) begin
                case (rv_uart_data[63:32])
                    32'h1f1a_5a01: gain_tgt_reg <= cmd_gain;
                    32'h1f1a_5a02: shift_reg <= ({28'd0, rv_uart_data[3:0]} > 32'(MAX_SHIFT)) ?
                                                4'd0 : rv_uart_data[3:0];
                    32'h1f1a_5a03: step_reg <= rv_uart_data[15:0];
                    32'h1f1a_5a3d: begin
                        if (rv_uart_data[31:0] == 32'd0) begin
                            uart_send_en <= 1'b1;
                            sd_uart_data <= {32'h1f1a_5a3d, cur_ext[15:0], 2'b00,
                                             state_reg, shift_reg, 8'h00};
                        end
                    end
                    default: ;
                endcase
            end

            // Ramp engine sees the pre-write target; a new command acts from the next cycle.
            if (step_reg == 16'd0) begin
                gain_cur_reg <= eff_tgt;
                state_reg    <= IDLE;
                presc_reg    <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        presc_reg <= '0;
                        if (cur_ext < tgt_ext)      state_reg <= UP;
                        else if (cur_ext > tgt_ext) state_reg <= DOWN;
                    end
                    UP: begin
                        if (cur_ext == tgt_ext) begin
                            state_reg <= IDLE;
                            presc_reg <= '0;
                        end else if (cur_ext > tgt_ext) begin
                            state_reg <= DOWN;
                        end else if (tick) begin
                            gain_cur_reg <= up_next;
                            presc_reg    <= '0;
                        end else begin
                            presc_reg <= presc_reg + 1'b1;
                        end
                    end
                    DOWN: begin
                        if (cur_ext == tgt_ext) begin
                            state_reg <= IDLE;
                            presc_reg <= '0;
                        end else if (cur_ext < tgt_ext) begin
                            state_reg <= UP;
                        end else if (tick) begin
                            gain_cur_reg <= dn_next;
                            presc_reg    <= '0;
                        end else begin
                            presc_reg <= presc_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        presc_reg <= '0;
                    end
                endcase
            end
        end
    end

    logic signed [GW-1:0] s1_gain_reg;
    logic [CH_NUM-1:0]    s1_stat_reg, s2_stat_reg;
    logic [7:0]           shamt;

    assign shamt = 8'(GW - 1) - {4'd0, shift_reg};

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            s1_gain_reg <= '0;
            s1_stat_reg <= '0;
            s2_stat_reg <= '0;
            dout_stat   <= '0;
        end else begin
            s1_gain_reg <= gain_cur_reg;
            s1_stat_reg <= din_stat;
            s2_stat_reg <= s1_stat_reg;
            dout_stat   <= s2_stat_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [DW-1:0] s1_smp_reg;
            logic signed [PW-1:0] s2_prod_reg;
            logic signed [PW-1:0] v;
            logic [DW-1:0]        sat;
            logic [DW-1:0]        dout_reg;

            always_comb begin
                v = s2_prod_reg >>> shamt;
                if (v > SAT_MAX)      sat = SAT_MAX[DW-1:0];
                else if (v < SAT_MIN) sat = SAT_MIN[DW-1:0];
                else                  sat = v[DW-1:0];
            end

            always_ff @(posedge clk_50m) begin
                if (rst) begin
                    s1_smp_reg  <= '0;
                    s2_prod_reg <= '0;
                    dout_reg    <= '0;
                end else begin
                    s1_smp_reg  <= data_in[gi*DW +: DW];
                    s2_prod_reg <= PW'(s1_smp_reg) * PW'(s1_gain_reg);
                    dout_reg    <= sat;
                end
            end

            assign data_out[gi*DW +: DW] = dout_reg;
        end
    endgenerate

endmodule

// File: tb/tb_iq_gain_ramp_ctrl.sv
// Directed bench for iq_gain_ramp_ctrl: datapath scaling/saturation, command decode,
// readback, ramp timing, power mute and reset behaviour.
module tb_iq_gain_ramp_ctrl;

    localparam int DW = 16;
    localparam int CH = 2;

    logic              clk_50m = 1'b0;
    logic              rst;
    logic              rv_uart_vld;
    logic [63:0]       rv_uart_data;
    logic              power_en;
    logic [CH-1:0]     din_stat;
    logic [CH*2*DW-1:0] data_in;
    logic [CH*2*DW-1:0] data_out;
    logic [CH-1:0]     dout_stat;
    logic              ramp_busy;
    logic              uart_send_en;
    logic [63:0]       sd_uart_data;

    int n_checks = 0;
    int n_err    = 0;
    int n_cyc;

    always #10 clk_50m = ~clk_50m;

    iq_gain_ramp_ctrl dut (
        .clk_50m      (clk_50m),
        .rst          (rst),
        .rv_uart_vld  (rv_uart_vld),
        .rv_uart_data (rv_uart_data),
        .power_en     (power_en),
        .din_stat     (din_stat),
        .data_in      (data_in),
        .data_out     (data_out),
        .dout_stat    (dout_stat),
        .ramp_busy    (ramp_busy),
        .uart_send_en (uart_send_en),
        .sd_uart_data (sd_uart_data)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic send_cmd(input logic [63:0] w);
        rv_uart_data = w;
        rv_uart_vld  = 1'b1;
        @(negedge clk_50m);
        rv_uart_vld  = 1'b0;
        rv_uart_data = '0;
    endtask

    task automatic readback(input string tag, input logic [15:0] g, input logic [1:0] st,
                            input logic [3:0] sh);
        send_cmd({32'h1f1a_5a3d, 32'h0});
        check_val({tag, "_en"}, 64'(uart_send_en), 64'd1);
        check_val({tag, "_word"}, sd_uart_data, {32'h1f1a_5a3d, g, 2'b00, st, sh, 8'h00});
        @(negedge clk_50m);
        check_val({tag, "_en_off"}, 64'(uart_send_en), 64'd0);
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (ramp_busy && n < max_cyc) begin
            @(negedge clk_50m);
            n++;
        end
        check_val({tag, "_idle"}, 64'(ramp_busy), 64'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        rv_uart_vld  = 1'b0;
        rv_uart_data = '0;
        power_en     = 1'b1;
        din_stat     = '0;
        data_in      = '0;
        repeat (3) @(negedge clk_50m);
        check_val("rst_data_out", 64'(data_out), 64'd0);
        check_val("rst_dout_stat", 64'(dout_stat), 64'd0);
        check_val("rst_send_en", 64'(uart_send_en), 64'd0);
        check_val("rst_sd_data", sd_uart_data, 64'd0);
        check_val("rst_busy", 64'(ramp_busy), 64'd0);
        rst = 1'b0;
        readback("rb_init", 16'h7FFF, 2'd0, 4'd0);

        // Unity gain, shift 0: floor(+16383.5)=3FFF, floor(-16383.5)=C000 (arithmetic shift).
        data_in  = {16'h8000, 16'h7FFF, 16'hC000, 16'h4000};
        din_stat = 2'b01;
        repeat (2) @(negedge clk_50m);
        check_val("lat2_data_out", 64'(data_out), 64'd0);
        @(negedge clk_50m);
        check_val("ch0_i", 64'(data_out[15:0]), 64'h3FFF);
        check_val("ch0_q", 64'(data_out[31:16]), 64'hC000);
        check_val("ch1_i", 64'(data_out[47:32]), 64'h7FFE);
        check_val("ch1_q", 64'(data_out[63:48]), 64'h8001);
        check_val("stat_01", 64'(dout_stat), 64'h1);
        din_stat = 2'b10;
        repeat (2) @(negedge clk_50m);
        check_val("stat_hold", 64'(dout_stat), 64'h1);
        @(negedge clk_50m);
        check_val("stat_10", 64'(dout_stat), 64'h2);

        // Shift 2 pushes every lane past full scale.
        send_cmd({32'h1f1a_5a02, 32'd2});
        data_in = {16'h8000, 16'h7FFF, 16'hD000, 16'h3000};
        repeat (3) @(negedge clk_50m);
        check_val("sat_pos", 64'(data_out[15:0]), 64'h7FFF);
        check_val("sat_neg", 64'(data_out[31:16]), 64'h8000);
        check_val("sat_ch1_pos", 64'(data_out[47:32]), 64'h7FFF);
        check_val("sat_ch1_neg", 64'(data_out[63:48]), 64'h8000);

        send_cmd({32'h1f1a_5a02, 32'd8});
        readback("rb_shift8", 16'h7FFF, 2'd0, 4'd8);
        send_cmd({32'h1f1a_5a02, 32'd9});
        data_in = {16'h8000, 16'h7FFF, 16'hC000, 16'h4000};
        repeat (3) @(negedge clk_50m);
        check_val("shift9_i", 64'(data_out[15:0]), 64'h3FFF);
        readback("rb_shift9", 16'h7FFF, 2'd0, 4'd0);

        send_cmd(64'h1f1a_5a04_0000_0000);
        check_val("bad_hdr_no_resp", 64'(uart_send_en), 64'd0);
        send_cmd(64'h1f1a_5a3d_0000_0001);
        check_val("bad_low_no_resp", 64'(uart_send_en), 64'd0);

        // Ramp 7FFF -> 0 in 0x100 steps: 128 ticks, busy for 6401 cycles.
        send_cmd({32'h1f1a_5a01, 32'h0});
        check_val("ramp_busy_lag", 64'(ramp_busy), 64'd0);
        n_cyc = 0;
        @(negedge clk_50m);
        while (ramp_busy && n_cyc < 8000) begin
            n_cyc++;
            @(negedge clk_50m);
        end
        check_val("ramp_len", 64'(n_cyc), 64'd6401);
        repeat (3) @(negedge clk_50m);
        check_val("ramp_data_zero", 64'(data_out), 64'd0);
        readback("rb_ramp_done", 16'h0000, 2'd0, 4'd0);

        // Ramp up to 7000; mute after 20 ticks.
        send_cmd({32'h1f1a_5a01, 32'h7000});
        repeat (1020) @(negedge clk_50m);
        power_en = 1'b0;
        @(negedge clk_50m);
        readback("rb_mute_down", 16'h1400, 2'd2, 4'd0);
        wait_idle("mute", 3000);
        readback("rb_muted", 16'h0000, 2'd0, 4'd0);
        power_en = 1'b1;
        repeat (2) @(negedge clk_50m);
        check_val("unmute_busy", 64'(ramp_busy), 64'd1);
        wait_idle("unmute", 7000);
        readback("rb_unmuted", 16'h7000, 2'd0, 4'd0);

        // Step 0 jumps straight to the target one cycle after the write.
        send_cmd({32'h1f1a_5a03, 32'h0});
        send_cmd({32'h1f1a_5a01, 32'h2000});
        readback("rb_jump_old", 16'h7000, 2'd0, 4'd0);
        readback("rb_jump_new", 16'h2000, 2'd0, 4'd0);
        send_cmd({32'h1f1a_5a01, 32'h0000_FFFF});
        @(negedge clk_50m);
        readback("rb_neg_clamp", 16'h0000, 2'd0, 4'd0);

        // Reset in the middle of a ramp.
        send_cmd({32'h1f1a_5a03, 32'h0100});
        send_cmd({32'h1f1a_5a01, 32'h7000});
        repeat (100) @(negedge clk_50m);
        check_val("midramp_busy", 64'(ramp_busy), 64'd1);
        check_val("midramp_data_nz", 64'(data_out[15:0] != 16'h0), 64'd1);
        rst = 1'b1;
        @(negedge clk_50m);
        check_val("midrst_busy", 64'(ramp_busy), 64'd0);
        check_val("midrst_data", 64'(data_out), 64'd0);
        check_val("midrst_stat", 64'(dout_stat), 64'd0);
        rst = 1'b0;
        readback("rb_after_rst", 16'h7FFF, 2'd0, 4'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
